// File: rtl/encoder_fec_pkg.sv
// rtl/encoder_fec_pkg.sv - shared randomizer state type, default constants and reference PRBS step
package encoder_fec_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } rand_state_e;

  localparam int                         RAND_DATA_W     = 8;
  localparam int                         RAND_LFSR_W     = 15;
  localparam logic [RAND_LFSR_W-1:0]     RAND_TAPS       = 15'h6000;
  localparam logic [RAND_LFSR_W-1:0]     RAND_SEED       = 15'h3715;
  localparam int                         RAND_BLOCK_BITS = 1536;

  // One beat of the default-width keystream: returns {next_lfsr, data ^ keystream}, MSB first in time.
  function automatic logic [RAND_LFSR_W+RAND_DATA_W-1:0] prbs_step(
    input logic [RAND_LFSR_W-1:0] lfsr,
    input logic [RAND_DATA_W-1:0] data
  );
    logic [RAND_LFSR_W-1:0] l;
    logic [RAND_DATA_W-1:0] o;
    logic                   fb;
    l = lfsr;
    o = '0;
    for (int k = 0; k < RAND_DATA_W; k++) begin
      fb                   = ^(l & RAND_TAPS);
      o[RAND_DATA_W-1-k]   = data[RAND_DATA_W-1-k] ^ fb;
      l                    = {l[RAND_LFSR_W-2:0], fb};
    end
    return {l, o};
  endfunction

endpackage

// File: rtl/prbs_keystream.sv
// rtl/prbs_keystream.sv - combinational DATA_W-step LFSR unroll, XORs keystream onto one beat
module prbs_keystream #(
  parameter int                DATA_W = 8,
  parameter int                LFSR_W = 15,
  parameter logic [LFSR_W-1:0] TAPS   = 15'h6000
) (
  input  logic [LFSR_W-1:0] lfsr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [LFSR_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] chain [DATA_W+1];

  assign chain[0] = lfsr_i;

  // Step k handles the k-th bit in time, which is data bit DATA_W-1-k.
  for (genvar k = 0; k < DATA_W; k++) begin : g_step
    logic fb;
    assign fb                  = ^(chain[k] & TAPS);
    assign data_o[DATA_W-1-k]  = data_i[DATA_W-1-k] ^ fb;
    assign chain[k+1]          = {chain[k][LFSR_W-2:0], fb};
  end

  assign lfsr_o = chain[DATA_W];

endmodule

// File: rtl/prbs_randomizer.sv
// rtl/prbs_randomizer.sv - streaming PRBS randomizer with block reload; RANDOMIZER_BYPASS_EN adds bypass port
module prbs_randomizer
  import encoder_fec_pkg::*;
#(
  parameter int                DATA_W     = RAND_DATA_W,
  parameter int                LFSR_W     = RAND_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS       = RAND_TAPS,
  parameter logic [LFSR_W-1:0] SEED       = RAND_SEED,
  parameter int                BLOCK_BITS = RAND_BLOCK_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef RANDOMIZER_BYPASS_EN
  input  logic              bypass,
`endif
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              blk_done
);

  localparam int               CNT_W    = $clog2(BLOCK_BITS + 1);
  localparam logic [CNT_W-1:0] STEP     = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BITS - DATA_W);

  rand_state_e       state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_cur, ks_lfsr;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, ks_data, beat_out;
  logic              m_last_q, m_last_d;
  logic              blk_done_q, blk_done_d;
  logic              accept, block_end;

  assign s_ready   = !m_valid_q || m_ready;
  assign accept    = s_valid && s_ready;
  assign block_end = s_last || (cnt_q == LAST_CNT);
  // An idle block always starts from SEED, whatever is left in the register.
  assign lfsr_cur  = (state_q == S_IDLE) ? SEED : lfsr_q;

  prbs_keystream #(
    .DATA_W(DATA_W),
    .LFSR_W(LFSR_W),
    .TAPS  (TAPS)
  ) u_keystream (
    .lfsr_i(lfsr_cur),
    .data_i(s_data),
    .data_o(ks_data),
    .lfsr_o(ks_lfsr)
  );

`ifdef RANDOMIZER_BYPASS_EN
  assign beat_out = bypass ? s_data : ks_data;
`else
  assign beat_out = ks_data;
`endif

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    blk_done_d = m_valid_q && m_ready && m_last_q;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = beat_out;
      m_last_d  = block_end;
      if (block_end) begin
        state_d = S_IDLE;
        lfsr_d  = SEED;
        cnt_d   = '0;
      end else begin
        state_d = S_RUN;
        lfsr_d  = ks_lfsr;
        cnt_d   = cnt_q + STEP;
      end
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      cnt_q      <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      blk_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      blk_done_q <= blk_done_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;
  assign blk_done = blk_done_q;

endmodule

// File: tb/tb_prbs_randomizer.sv
// tb/tb_prbs_randomizer.sv - randomized bench: default randomizer chained into a derandomizer, plus small config
module tb_prbs_randomizer;
  import encoder_fec_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s_valid = 1'b0, s_last = 1'b0, byp = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready, m_valid, m_last, blk_done, l_ready;
  logic [7:0] m_data;
  logic       i_valid, i_last, i_done;
  logic       i_ready = 1'b1;
  logic [7:0] i_data;
  logic       i_s_ready_unused;

  logic       ds_valid = 1'b0, ds_ready = 1'b1;
  logic [6:0] ds_data = 7'h00, dm_data;
  logic       ds_s_ready, dm_valid, dm_last, dm_done;

  prbs_randomizer dut (
    .clk(clk), .rst_n(rst_n),
`ifdef RANDOMIZER_BYPASS_EN
    .bypass(byp),
`endif
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(l_ready), .m_data(m_data), .m_last(m_last),
    .blk_done(blk_done)
  );

  prbs_randomizer inv (
    .clk(clk), .rst_n(rst_n),
`ifdef RANDOMIZER_BYPASS_EN
    .bypass(1'b0),
`endif
    .s_valid(m_valid), .s_ready(l_ready), .s_data(m_data), .s_last(m_last),
    .m_valid(i_valid), .m_ready(i_ready), .m_data(i_data), .m_last(i_last),
    .blk_done(i_done)
  );

  prbs_randomizer #(
    .DATA_W(7), .LFSR_W(3), .TAPS(3'b110), .SEED(3'b001), .BLOCK_BITS(14)
  ) dut_s (
    .clk(clk), .rst_n(rst_n),
`ifdef RANDOMIZER_BYPASS_EN
    .bypass(1'b0),
`endif
    .s_valid(ds_valid), .s_ready(ds_s_ready), .s_data(ds_data), .s_last(1'b0),
    .m_valid(dm_valid), .m_ready(ds_ready), .m_data(dm_data), .m_last(dm_last),
    .blk_done(dm_done)
  );

  assign i_s_ready_unused = i_done;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  localparam int TAPS_I = 'h6000;
  localparam int SEED_I = 'h3715;

  // Keystream taken straight from the rule: feedback is the parity of the tapped bits.
  function automatic void ref_step(input int lf, input logic [7:0] d, output logic [7:0] o, output int nl);
    logic fb;
    nl = lf;
    for (int k = 7; k >= 0; k--) begin
      fb   = ($countones(nl & TAPS_I) % 2) == 1;
      o[k] = d[k] ^ fb;
      nl   = ((nl << 1) | int'(fb)) & 'h7fff;
    end
  endfunction

  int         mdl_lfsr = SEED_I;
  int         mdl_cnt  = 0;
  logic [8:0] exp_q[$];
  logic [8:0] in_q[$];
  logic [7:0] out_log[$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_out   = '0;
  logic       exp_done   = 1'b0;

  task automatic model_accept(input logic [7:0] d, input logic l, input logic b);
    logic [7:0] ks;
    int         nl;
    logic       e;
    ref_step(mdl_lfsr, 8'h00, ks, nl);
    e = l || (mdl_cnt + 8 == 1536);
    exp_q.push_back({e, b ? d : (d ^ ks)});
    in_q.push_back({e, b ? (d ^ ks) : d});
    if (e) begin
      mdl_lfsr = SEED_I;
      mdl_cnt  = 0;
    end else begin
      mdl_lfsr = nl;
      mdl_cnt += 8;
    end
  endtask

  task automatic model_reset();
    mdl_lfsr   = SEED_I;
    mdl_cnt    = 0;
    exp_q.delete();
    in_q.delete();
    prev_stall = 1'b0;
    exp_done   = 1'b0;
  endtask

  task automatic cycle(input logic sv, input logic [7:0] sd, input logic sl, input logic b, input logic rdy);
    logic       eb;
    logic [8:0] e;
    @(negedge clk);
    if (prev_stall) check("stall_hold", {m_last, m_data}, prev_out);
    check("blk_done", blk_done, exp_done);
    s_valid = sv; s_data = sd; s_last = sl; byp = b; i_ready = rdy;
`ifdef RANDOMIZER_BYPASS_EN
    eb = b;
`else
    eb = 1'b0;
`endif
    #1;
    check("s_ready", s_ready, !(m_valid && !l_ready));
    if (s_valid && s_ready) model_accept(s_data, s_last, eb);
    if (m_valid && l_ready) begin
      out_log.push_back(m_data);
      if (exp_q.size() == 0) check("dut_extra_beat", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("dut_data", m_data, e[7:0]);
        check("dut_last", m_last, e[8]);
      end
    end
    if (i_valid && i_ready) begin
      if (in_q.size() == 0) check("inv_extra_beat", 1, 0);
      else begin
        e = in_q.pop_front();
        check("inv_data", i_data, e[7:0]);
        check("inv_last", i_last, e[8]);
      end
    end
    prev_stall = m_valid && !l_ready;
    prev_out   = {m_last, m_data};
    exp_done   = m_valid && l_ready && m_last;
    @(posedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && (exp_q.size() != 0 || in_q.size() != 0); n++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("drain_dut", exp_q.size(), 0);
    check("drain_inv", in_q.size(), 0);
  endtask

  task automatic mid_reset();
    for (int n = 0; n < 4; n++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("pre_reset_valid", m_valid, 1);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_inv_valid", i_valid, 0);
    check("rst_s_ready", s_ready, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    logic [7:0] first_a, o;
    int         nl;
    logic [22:0] ps;

    repeat (2) @(negedge clk);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_data", m_data, 0);
    check("reset_m_last", m_last, 0);
    check("reset_blk_done", blk_done, 0);
    check("reset_s_ready", s_ready, 1);
    rst_n = 1'b1;

    for (int t = 0; t < 3; t++) begin
      s_data = 8'($urandom);
      ref_step(SEED_I, s_data, o, nl);
      ps = prbs_step(RAND_SEED, s_data);
      check("pkg_prbs_step", ps, {15'(nl), o});
    end

    ds_valid = 1'b1; ds_data = 7'h00; ds_ready = 1'b1;
    @(negedge clk);
    check("small_beat1", {dm_valid, dm_last, dm_data}, {2'b10, 7'h39});
    @(negedge clk);
    check("small_beat2", {dm_valid, dm_last, dm_data}, {2'b11, 7'h39});
    check("small_done_early", dm_done, 0);
    ds_valid = 1'b0;
    @(negedge clk);
    check("small_done", dm_done, 1);
    @(negedge clk);
    check("small_done_pulse", dm_done, 0);
    @(posedge clk);

    out_log.delete();
    for (int n = 0; n < 384; n++) cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    drain();
    check("blockA_beats", out_log.size(), 384);
    if (out_log.size() == 384)
      for (int n = 0; n < 192; n++) check("block2_eq_block1", out_log[n+192], out_log[n]);
    first_a = (out_log.size() != 0) ? out_log[0] : 8'hxx;

    out_log.delete();
    for (int n = 0; n < 6; n++) cycle(1'b1, 8'h00, n == 4, 1'b0, 1'b1);
    drain();
    check("slast_beats", out_log.size(), 6);
    if (out_log.size() == 6) begin
      check("slast_restart", out_log[5], out_log[0]);
      check("slast_first", out_log[0], first_a);
    end

`ifdef RANDOMIZER_BYPASS_EN
    cycle(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 4; n++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1);
    drain();
`endif

    for (int n = 0; n < 700; n++)
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 39) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    mid_reset();
    for (int n = 0; n < 500; n++)
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 39) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
